// File: rtl/vpu_pkg.sv
// Shared types and constants for the systolic operand path.
// The default data width matches the MAC cell.
package vpu_pkg;

    localparam int VPU_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        FLUSH,
        DONE
    } feeder_state_e;

    // Zero beats needed to push the last product through the far corner cell.
    function automatic int flush_cycles(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/systolic_operand_feeder_skew_line.sv
// Enable-gated delay line: one lane of the diagonal operand skew.
// Output q is the oldest of DEPTH stored samples.
module skew_line
    import vpu_pkg::*;
#(
    parameter int DATA_WIDTH = VPU_DATA_WIDTH,
    parameter int DEPTH      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else if (shift) begin
            r_stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign q = r_stage[DEPTH-1];

endmodule

// File: rtl/systolic_operand_feeder.sv
// Feeds skewed A/B operand lanes into an N x N systolic MAC array,
// sequencing clear, streaming, zero-flush and a done pulse per job.
module systolic_operand_feeder
    import vpu_pkg::*;
#(
    parameter int DATA_WIDTH = VPU_DATA_WIDTH,
    parameter int N          = 4,
    parameter int K_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [K_WIDTH-1:0]      k_len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*DATA_WIDTH-1:0] a_vec,
    input  logic [N*DATA_WIDTH-1:0] b_vec,
    output logic [N*DATA_WIDTH-1:0] out_left,
    output logic [N*DATA_WIDTH-1:0] out_top,
    output logic                    arr_en,
    output logic                    arr_clr,
    output logic                    busy,
    output logic                    done
);

    localparam int              FLUSH_CYCLES = flush_cycles(N);
    localparam int              FC_W         = $clog2(2 * N);
    localparam logic [FC_W-1:0] FLUSH_LAST   = FC_W'(FLUSH_CYCLES - 1);

    feeder_state_e r_state;
    feeder_state_e w_next;

    logic [K_WIDTH-1:0]      r_klen;
    logic [K_WIDTH-1:0]      r_beat;
    logic [FC_W-1:0]         r_flush;
    logic                    r_arr_en;
    logic                    w_advance;
    logic                    w_last_beat;
    logic [N*DATA_WIDTH-1:0] w_a_in;
    logic [N*DATA_WIDTH-1:0] w_b_in;

    assign w_advance   = ((r_state == STREAM) && in_valid) || (r_state == FLUSH);
    assign w_last_beat = (r_beat == r_klen - K_WIDTH'(1));

    // Outside STREAM the lines are fed zeros so the flush drains the array.
    assign w_a_in = (r_state == STREAM) ? a_vec : '0;
    assign w_b_in = (r_state == STREAM) ? b_vec : '0;

    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = CLEAR;
            CLEAR:   w_next = (r_klen == '0) ? DONE : STREAM;
            STREAM:  if (w_advance && w_last_beat) w_next = FLUSH;
            FLUSH:   if (r_flush == FLUSH_LAST) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_klen   <= '0;
            r_beat   <= '0;
            r_flush  <= '0;
            r_arr_en <= 1'b0;
        end else begin
            // Enable is delayed one cycle to line up with the skew line outputs.
            r_arr_en <= w_advance;
            if (r_state == IDLE && start) r_klen <= k_len;
            if (r_state == CLEAR)
                r_beat <= '0;
            else if (r_state == STREAM && w_advance)
                r_beat <= r_beat + K_WIDTH'(1);
            r_flush <= (r_state == FLUSH) ? r_flush + FC_W'(1) : '0;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        skew_line #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(g + 1)) u_skew_a (
            .clk   (clk),
            .rst   (rst),
            .shift (w_advance),
            .d     (w_a_in[g*DATA_WIDTH +: DATA_WIDTH]),
            .q     (out_left[g*DATA_WIDTH +: DATA_WIDTH])
        );
        skew_line #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(g + 1)) u_skew_b (
            .clk   (clk),
            .rst   (rst),
            .shift (w_advance),
            .d     (w_b_in[g*DATA_WIDTH +: DATA_WIDTH]),
            .q     (out_top[g*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    assign in_ready = (r_state == STREAM);
    assign arr_clr  = (r_state == CLEAR);
    assign done     = (r_state == DONE);
    assign busy     = (r_state != IDLE);
    assign arr_en   = r_arr_en;

endmodule

// File: doc/systolic_operand_feeder.md
Name: systolic_operand_feeder

Overview:
- Transmit side of the MAC cell operand interface: drives the in_left / in_top edges of an N x N systolic MAC array.
- Accepts one unskewed A-column vector and one B-row vector per k-step over a valid/ready handshake, and applies the diagonal skew (lane i delayed i extra beats).
- Drains the array with zero beats, pulses an accumulator clear before each job and done after the last product has landed.
- Sits between the operand buffers/DMA and the MAC array.

Parameters:
- DATA_WIDTH, 8, operand width per lane; matches the MAC cell DATA_WIDTH.
- N, 4, array dimension (lanes per edge); legal range 2..16.
- K_WIDTH, 16, width of k_len.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low (0 = reset)
- start  in  1  begin job; sampled only in IDLE
- k_len  in  K_WIDTH  number of k-steps (beats) in the job; sampled with start
- in_valid  in  1  a_vec/b_vec hold a beat
- in_ready  out  1  feeder accepts a beat this cycle
- a_vec  in  N*DATA_WIDTH  A column, lane i = bits [i*DATA_WIDTH +: DATA_WIDTH]; lane i feeds row i
- b_vec  in  N*DATA_WIDTH  B row, lane j feeds column j
- out_left  out  N*DATA_WIDTH  skewed A lanes to array left edge
- out_top  out  N*DATA_WIDTH  skewed B lanes to array top edge
- arr_en  out  1  array-wide MAC enable; 1 only on advance cycles
- arr_clr  out  1  one-cycle accumulator clear pulse
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; all accumulators final

Behaviour:
- Reset (rst==0 at a clk edge): state IDLE; all skew registers, counters and outputs 0. Reset mid-job aborts immediately; no done.
- States: IDLE, CLEAR, STREAM, FLUSH, DONE.
- IDLE:
  - start==1: latch k_len, go to CLEAR.
  - start==0: stay in IDLE.
  - start is ignored in every state other than IDLE.
- CLEAR (1 cycle): arr_clr=1, arr_en=0.
  - k_len==0: go to DONE (no stream, no flush).
  - Otherwise: go to STREAM.
- STREAM:
  - in_ready=1.
  - advance = in_valid & in_ready.
  - On advance: the beat enters the skew lines and the beat counter increments.
  - No advance: skew lines hold and arr_en=0; array stalls cleanly.
  - After beat k_len is accepted: go to FLUSH; in_ready drops the next cycle.
- FLUSH:
  - advance=1 every cycle; zero lanes are injected.
  - Lasts exactly FLUSH_CYCLES = 2*N-1 cycles, then go to DONE.
- DONE (1 cycle): done=1, then go to IDLE.
- in_ready=0 outside STREAM. in_valid is ignored there.
- arr_en = advance, registered in phase with the output registers: arr_en is 1 in the cycle the corresponding skewed data is on out_left/out_top.
- Skew:
  - Lane i of A and lane j of B pass through i+1 and j+1 register stages respectively.
  - Registers shift only on advance.
  - A beat accepted on advance edge t appears on lane 0 after edge t, and on lane i after the i-th subsequent advance edge.
- Widths: pure data movement; no arithmetic on operands.
- beat and flush counters: $clog2(2*N)-bit flush counter; K_WIDTH-bit beat counter. No wrap within a legal job (k_len max 2^K_WIDTH-1).
- Simultaneous events:
  - start in DONE is ignored; it must be re-asserted in IDLE.
  - in_valid held high across the STREAM-to-FLUSH boundary: only k_len beats are accepted.

Decomposition:
- Package vpu_pkg:
  - typedef feeder_state_e {IDLE, CLEAR, STREAM, FLUSH, DONE}
  - localparam function flush_cycles(N) = 2*N-1
  - DATA_WIDTH default, shared with the MAC cell.
- Sub-module skew_line (params DATA_WIDTH, DEPTH; ports clk, rst, shift, d, q): enable-gated shift register, instantiated 2*N times via generate with DEPTH = lane+1.
- Top holds the FSM, counters and handshake.

Test Plan (N=4, DATA_WIDTH=8):
- Reset: rst=0 for 2 cycles mid-STREAM -> next cycle IDLE; all outputs 0; no done.
- k_len=1, a_vec lanes {1,2,3,4}, b_vec lanes {5,6,7,8}, in_valid=1:
  - arr_clr at cycle 1; accept at cycle 2.
  - out_left lane0=1 one cycle later, lane3=4 three advances after lane0.
  - done exactly 1+1+7+1 cycles after start; in_ready high for 1 cycle.
- Backpressure stall: k_len=3, in_valid toggles 1,0,0,1,1 -> arr_en low during the gaps; out_left/out_top hold their values; skew offsets relative to advances are unchanged; 3 beats accepted.
- End-to-end with the MAC array model: A = 4x4 identity, B = ramp 1..16, k_len=4 -> on done, acc_out equals B element-wise; zero residue from the prior job, which verifies arr_clr.
- k_len=0 -> CLEAR, then done on the next cycle; in_ready never high; arr_en never high.
- Illegal start: start pulsed during STREAM and during DONE -> ignored; one done per accepted start; busy is 0 only in IDLE.
